// File: rtl/count_pwm.sv
// Double-buffered PWM driven by an 8-bit duty command, with programmable tick prescaler.
// Define PWM_COMP_OUT_EN to add the dead-time-protected complementary output pwm_n_out.
module count_pwm #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned DEADTIME = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] duty_in,
  input  logic       duty_valid,
  output logic       pwm_out,
  output logic       period_start,
  output logic [7:0] duty_active
`ifdef PWM_COMP_OUT_EN
  ,
  output logic       pwm_n_out
`endif
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pending_q;
  logic [7:0]  phase_q, phase_d;
  logic [15:0] prescaler_q, prescaler_d;
  logic [7:0]  duty_active_d;
  logic        period_start_d;
  logic        pwm_raw_q, pwm_raw_d;
  logic [7:0]  load_val;
  logic        tick;

  always_comb begin
    // A strobe in the same cycle as a load wins over the buffered value.
    load_val       = duty_valid ? duty_in : pending_q;
    tick           = (prescaler_q == 16'(PRESCALE - 1));
    state_d        = state_q;
    phase_d        = phase_q;
    prescaler_d    = prescaler_q;
    duty_active_d  = duty_active;
    period_start_d = 1'b0;

    case (state_q)
      StIdle: begin
        phase_d       = 8'd0;
        prescaler_d   = 16'd0;
        duty_active_d = load_val;
        if (enable) begin
          state_d        = StRun;
          period_start_d = 1'b1;
        end
      end
      StRun: begin
        if (!enable) begin
          state_d     = StIdle;
          phase_d     = 8'd0;
          prescaler_d = 16'd0;
        end else begin
          prescaler_d = tick ? 16'd0 : prescaler_q + 16'd1;
          if (tick) begin
            phase_d = phase_q + 8'd1;
            if (phase_q == 8'hff) begin
              duty_active_d  = load_val;
              period_start_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    pwm_raw_d = (state_d == StRun) && (phase_d < duty_active_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pending_q    <= 8'd0;
      phase_q      <= 8'd0;
      prescaler_q  <= 16'd0;
      duty_active  <= 8'd0;
      period_start <= 1'b0;
      pwm_raw_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (duty_valid) pending_q <= duty_in;
      phase_q      <= phase_d;
      prescaler_q  <= prescaler_d;
      duty_active  <= duty_active_d;
      period_start <= period_start_d;
      pwm_raw_q    <= pwm_raw_d;
    end
  end

`ifdef PWM_COMP_OUT_EN
  localparam logic [3:0] DeadCnt = 4'(DEADTIME);

  logic       tgt_p_d, tgt_n_d, tgt_n_q;
  logic [3:0] cnt_p_q, cnt_n_q, cnt_p_d, cnt_n_d;

  // Each counter measures how long its target level has been held; an output
  // may rise only once its target has survived DEADTIME clocks.
  assign tgt_n_q = (state_q == StRun) && !pwm_raw_q;

  always_comb begin
    tgt_p_d = pwm_raw_d;
    tgt_n_d = (state_d == StRun) && !pwm_raw_d;
    cnt_p_d = 4'd0;
    cnt_n_d = 4'd0;
    if (tgt_p_d && pwm_raw_q) cnt_p_d = (cnt_p_q == DeadCnt) ? cnt_p_q : cnt_p_q + 4'd1;
    if (tgt_n_d && tgt_n_q)   cnt_n_d = (cnt_n_q == DeadCnt) ? cnt_n_q : cnt_n_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p_q   <= 4'd0;
      cnt_n_q   <= 4'd0;
      pwm_out   <= 1'b0;
      pwm_n_out <= 1'b0;
    end else begin
      cnt_p_q   <= cnt_p_d;
      cnt_n_q   <= cnt_n_d;
      pwm_out   <= tgt_p_d && (cnt_p_d == DeadCnt);
      pwm_n_out <= tgt_n_d && (cnt_n_d == DeadCnt);
    end
  end
`else
  logic [3:0] unused_deadtime;
  assign unused_deadtime = 4'(DEADTIME);
  assign pwm_out         = pwm_raw_q;
`endif

endmodule
